// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Purpose : host-side byte handshake, frame configuration and serial-line
//           signals of the UART transmitter, bundled as one interface.
// Signals :
//   tx_data_i    [7:0] byte to send
//   tx_valid_i         byte and configuration are valid
//   tx_ready_o         transmitter idle, will accept a byte
//   bit_used_i   [3:0] 8 = data only, 9 = data + parity, others behave as 8
//   parity_odd_i       0 = even parity, 1 = odd parity
//   tx_o               serial line, idles high
//   tx_busy_o          frame in progress
//   tx_done_o          one-cycle pulse in the last cycle of the stop bit
// Modports: master = host / bench side, slave = transmitter.
// ---------------------------------------------------------------------------
interface uart_tx_frame_if;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [3:0] bit_used_i;
    logic       parity_odd_i;
    logic       tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    modport master (
        output tx_data_i, tx_valid_i, bit_used_i, parity_odd_i,
        input  tx_ready_o, tx_o, tx_busy_o, tx_done_o
    );

    modport slave (
        input  tx_data_i, tx_valid_i, bit_used_i, parity_odd_i,
        output tx_ready_o, tx_o, tx_busy_o, tx_done_o
    );
endinterface

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Purpose : UART transmitter. Accepts one byte per valid/ready handshake and
//           sends start bit, 8 data bits LSB first, optional parity bit and
//           one stop bit. All outputs are registered.
// Ports   :
//   clk_i  clock, rising edge
//   rst_i  asynchronous reset, active high
//   bus    uart_tx_frame_if.slave (handshake, config, serial line, status)
// Params  : CLK_DIV clock cycles per serial bit (>= 2)
// Macro   : UART_TX_PARITY_EN - when defined, bit_used_i = 9 adds a parity
//           bit (parity_odd_i selects odd/even). When undefined the parity
//           path is absent and every frame is 10 bits.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line high, ready for a byte
// S_START  | start bit (line low)
// S_DATA   | data bit r_idx, LSB first
// S_PARITY | parity bit (only with UART_TX_PARITY_EN)
// S_STOP   | stop bit (line high)
// ---------------------------------------------------------------------------
module uart_tx_frame #(
    parameter int CLK_DIV = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    uart_tx_frame_if.slave   bus
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_data;
    logic            r_tx;
    logic            r_ready;
    logic            r_done;

    state_t          w_next_state;
    logic [CW-1:0]   w_next_cnt;
    logic [2:0]      w_next_idx;
    logic            w_next_tx;
    logic            w_next_done;
    logic            w_accept;
    logic            w_tc;

`ifdef UART_TX_PARITY_EN
    logic            r_par_en;
    logic            r_odd;
`else
    logic            w_unused_cfg;
    assign w_unused_cfg = ^{bus.bit_used_i, bus.parity_odd_i};
`endif

    assign w_accept = bus.tx_valid_i & r_ready;
    assign w_tc     = (r_cnt == TC);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par_en <= 1'b0;
            r_odd    <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            r_idx   <= w_next_idx;
            r_tx    <= w_next_tx;
            r_ready <= (w_next_state == S_IDLE);
            r_done  <= w_next_done;
            if (w_accept) begin
                r_data <= bus.tx_data_i;
`ifdef UART_TX_PARITY_EN
                r_par_en <= (bus.bit_used_i == 4'd9);
                r_odd    <= bus.parity_odd_i;
`endif
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_idx   = r_idx;

        // Baud counter runs in every non-idle state and wraps at terminal count.
        if (r_state != S_IDLE) begin
            w_next_cnt = w_tc ? '0 : r_cnt + CW'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_START;
                    w_next_cnt   = '0;
                    w_next_idx   = '0;
                end
            end
            S_START: begin
                if (w_tc) w_next_state = S_DATA;
            end
            S_DATA: begin
                if (w_tc) begin
                    w_next_idx = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_next_state = r_par_en ? S_PARITY : S_STOP;
`else
                        w_next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_tc) w_next_state = S_STOP;
            end
`endif
            S_STOP: begin
                if (w_tc) w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
                w_next_idx   = '0;
            end
        endcase
    end

    // Line and done values are derived from the next state so both are
    // registered and line up with the state they describe.
    always_comb begin
        w_next_tx = 1'b1;
        case (w_next_state)
            S_START:  w_next_tx = 1'b0;
            S_DATA:   w_next_tx = r_data[w_next_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_next_tx = (^r_data) ^ r_odd;
`endif
            default:  w_next_tx = 1'b1;
        endcase
        w_next_done = (w_next_state == S_STOP) && (w_next_cnt == TC);
    end

    assign bus.tx_o       = r_tx;
    assign bus.tx_ready_o = r_ready;
    assign bus.tx_busy_o  = ~r_ready;
    assign bus.tx_done_o  = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
module tb_uart_tx_frame;

    localparam int CD = 4;

    typedef struct {
        logic [10:0] bits;
        int          nbits;
    } frame_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     n_checks = 0;
    int     n_errors = 0;
    frame_t sb_q[$];

    uart_tx_frame_if bus();

    uart_tx_frame #(.CLK_DIV(CD)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic frame_t make_frame(input logic [7:0] d, input logic [3:0] bu, input logic odd);
        frame_t f;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[i+1] = d[i];
        f.nbits = 10;
`ifdef UART_TX_PARITY_EN
        if (bu == 4'd9) begin
            f.bits[9] = (^d) ^ odd;
            f.nbits   = 11;
        end
`else
        if (bu == 4'd9 && odd === 1'bx) f.nbits = 10;
`endif
        return f;
    endfunction

    // Pops one expected frame and checks every cycle of it plus the idle
    // cycle after it. mode 0: drop valid after accept; mode 1: keep valid and
    // present next_data for a back-to-back frame; mode 2: keep valid and
    // disturb the inputs mid-frame, dropping valid in the last frame cycle.
    task automatic check_frame(input string nm, input int mode, input logic [7:0] next_data);
        frame_t     f;
        int         len;
        int         bi;
        logic [3:0] got;
        logic [3:0] exp;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, required one expected frame", nm);
            return;
        end
        f   = sb_q.pop_front();
        len = f.nbits * CD;
        n_checks++;
        if (bus.tx_ready_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s accept: tx_ready_o=%b required 1", nm, bus.tx_ready_o);
        end
        @(posedge clk);
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            bi  = k / CD;
            got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
            exp = {f.bits[bi], 1'b1, 1'b0, (k == len - 1)};
            n_checks++;
            if (got !== exp) begin
                n_errors++;
                $display("FAIL %s cycle %0d: tx/busy/ready/done=%b required %b", nm, k, got, exp);
            end
            case (mode)
                0: if (k == 0) bus.tx_valid_i = 1'b0;
                1: if (k == 0) bus.tx_data_i = next_data;
                2: begin
                    if (k == 18) begin
                        bus.tx_data_i    = next_data;
                        bus.bit_used_i   = (bus.bit_used_i == 4'd9) ? 4'd8 : 4'd9;
                        bus.parity_odd_i = ~bus.parity_odd_i;
                    end
                    if (k == len - 1) bus.tx_valid_i = 1'b0;
                end
                default: ;
            endcase
        end
        @(negedge clk);
        got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
        n_checks++;
        if (got !== 4'b1010) begin
            n_errors++;
            $display("FAIL %s idle after frame: tx/busy/ready/done=%b required 1010", nm, got);
        end
    endtask

    task automatic send(input string nm, input logic [7:0] d, input logic [3:0] bu, input logic odd);
        @(negedge clk);
        bus.tx_data_i    = d;
        bus.bit_used_i   = bu;
        bus.parity_odd_i = odd;
        bus.tx_valid_i   = 1'b1;
        sb_q.push_back(make_frame(d, bu, odd));
        check_frame(nm, 0, 8'h00);
    endtask

    task automatic test_reset();
        logic [3:0] got;
        @(negedge clk);
        got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
        n_checks++;
        if (got !== 4'b1010) begin
            n_errors++;
            $display("FAIL reset_state: tx/busy/ready/done=%b required 1010", got);
        end
        rst = 1'b0;
        @(negedge clk);
        got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
        n_checks++;
        if (got !== 4'b1010) begin
            n_errors++;
            $display("FAIL post_reset_idle: tx/busy/ready/done=%b required 1010", got);
        end
    endtask

    task automatic test_frames();
        logic [7:0] d_tbl [5];
        logic [3:0] bu_tbl[5];
        logic       od_tbl[5];
        d_tbl  = '{8'h55, 8'hA3, 8'hA3, 8'hC6, 8'hFF};
        bu_tbl = '{4'd8,  4'd9,  4'd9,  4'd5,  4'd9};
        od_tbl = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
        for (int i = 0; i < 5; i++) begin
            send($sformatf("frame%0d_%02h", i, d_tbl[i]), d_tbl[i], bu_tbl[i], od_tbl[i]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.tx_data_i    = 8'h0F;
        bus.bit_used_i   = 4'd8;
        bus.parity_odd_i = 1'b0;
        bus.tx_valid_i   = 1'b1;
        sb_q.push_back(make_frame(8'h0F, 4'd8, 1'b0));
        sb_q.push_back(make_frame(8'hF0, 4'd8, 1'b0));
        check_frame("b2b_first", 1, 8'hF0);
        check_frame("b2b_second", 0, 8'h00);
    endtask

    task automatic test_mid_change();
        logic [3:0] got;
        @(negedge clk);
        bus.tx_data_i    = 8'h5A;
        bus.bit_used_i   = 4'd8;
        bus.parity_odd_i = 1'b0;
        bus.tx_valid_i   = 1'b1;
        sb_q.push_back(make_frame(8'h5A, 4'd8, 1'b0));
        check_frame("mid_change", 2, 8'hFF);
        @(negedge clk);
        got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
        n_checks++;
        if (got !== 4'b1010) begin
            n_errors++;
            $display("FAIL mid_change no_reaccept: tx/busy/ready/done=%b required 1010", got);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] got;
        @(negedge clk);
        bus.tx_data_i    = 8'h00;
        bus.bit_used_i   = 4'd8;
        bus.parity_odd_i = 1'b0;
        bus.tx_valid_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.tx_valid_i = 1'b0;
        repeat (17) @(negedge clk);
        got = {bus.tx_o, bus.tx_busy_o};
        n_checks++;
        if (got !== 2'b01) begin
            n_errors++;
            $display("FAIL reset_mid before: tx/busy=%b required 01", got);
        end
        rst = 1'b1;
        #1;
        got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
        n_checks++;
        if (got !== 4'b1010) begin
            n_errors++;
            $display("FAIL reset_mid async: tx/busy/ready/done=%b required 1010", got);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 3) rst = 1'b0;
            got = {bus.tx_o, bus.tx_busy_o, bus.tx_ready_o, bus.tx_done_o};
            n_checks++;
            if (got !== 4'b1010) begin
                n_errors++;
                $display("FAIL reset_mid hold cycle %0d: tx/busy/ready/done=%b required 1010", k, got);
            end
        end
        send("after_reset_81", 8'h81, 4'd8, 1'b0);
    endtask

    initial begin
        bus.tx_data_i    = 8'h00;
        bus.tx_valid_i   = 1'b0;
        bus.bit_used_i   = 4'd8;
        bus.parity_odd_i = 1'b0;
        test_reset();
        test_frames();
        test_back_to_back();
        test_mid_change();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d frames left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial UART transmitter that takes one byte per valid/ready handshake and sends it LSB-first on a single line. A frame is a start bit, 8 data bits, an optional parity bit and one stop bit. Frame length follows the same `bit_used` encoding as the receive-side bit counter: 8 gives a 10-bit frame, 9 gives an 11-bit frame. The block sits between the register/host interface and the TX pin, and mirrors the UART receive path.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; must be ≥ 2.
- `clk_i` input 1: clock, rising-edge.
- `rst_i` input 1: asynchronous reset, active-high.
- `tx_data_i` input 8: byte to send.
- `tx_valid_i` input 1: byte and config are valid.
- `tx_ready_o` output 1: block is idle and can accept a byte.
- `bit_used_i` input 4: 8 = data only, 9 = data + parity; any other value behaves as 8.
- `parity_odd_i` input 1: 0 = even parity, 1 = odd parity (used only when parity is enabled).
- `tx_o` output 1: serial line; idles high.
- `tx_busy_o` output 1: a frame is in progress.
- `tx_done_o` output 1: one-cycle pulse in the last cycle of the stop bit.

## Operation
- Reset values:
  - `tx_o`=1, `tx_ready_o`=1, `tx_busy_o`=0, `tx_done_o`=0.
  - FSM in IDLE; baud counter and bit index at 0.
- Accept: a byte is taken on a rising edge where `tx_valid_i` & `tx_ready_o`. At that edge the block latches `tx_data_i`, the effective `bit_used_i` and `parity_odd_i`. Inputs are don't-care outside acceptance.
- FSM states and transitions:
  - IDLE → START on accept.
  - START drives `tx_o`=0 for one bit time.
  - START → DATA. DATA drives data bit `idx`, where `idx` runs 0..7 (LSB first).
  - DATA → PARITY when `idx`=7 and parity is enabled; otherwise DATA → STOP.
  - PARITY drives the XOR of the 8 latched bits, XORed with the latched odd flag.
  - STOP drives `tx_o`=1 for one bit time, then → IDLE.
- Baud counter:
  - Width is `$clog2(CLK_DIV)`.
  - Counts 0..`CLK_DIV`-1 in every non-IDLE state.
  - Wraps to 0 and advances the bit at terminal count.
- Bit index: 3 bits; advances only in DATA at the baud terminal count.
- Frame length: exactly 10×`CLK_DIV` cycles when `bit_used`=8, and 11×`CLK_DIV` cycles when `bit_used`=9.
- `tx_ready_o`=1 only in IDLE. `tx_busy_o` is its complement.
- Reset asserted mid-frame: all state is abandoned at once (asynchronously). `tx_o` goes high and no `tx_done_o` pulse is produced.

## Timing
- Outputs are registered; `tx_o` changes only on clock edges, except on reset.
- Accept at edge N: `tx_o`=0 and `tx_busy_o`=1 from edge N onward. The start bit occupies cycles N..N+`CLK_DIV`-1.
- `tx_done_o` is high for exactly the last cycle of STOP. `tx_ready_o` rises on the following edge.
- Back-to-back: if `tx_valid_i` is held high, the next byte is accepted on the first IDLE cycle. The next start bit then begins one cycle later, so stop is 1 bit time plus 1 clock.
- `tx_valid_i` is ignored while `tx_ready_o`=0. Changing the inputs mid-frame has no effect.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state, `parity_odd_i` and `bit_used_i`=9 behave as described above.
- Undefined:
  - PARITY state and parity logic are not compiled.
  - `bit_used_i` and `parity_odd_i` are ignored (ports remain but are unused).
  - Every frame is 10 bits.

## Test plan
- `CLK_DIV`=4, `bit_used`=8, send 0x55 → `tx_o` = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles. `tx_done_o` pulses in cycle 39 after accept; `tx_ready_o` is back at cycle 40.
- Macro on, `CLK_DIV`=4, `bit_used`=9, send 0xA3:
  - `parity_odd`=0 → parity bit 0.
  - `parity_odd`=1 → parity bit 1.
  - Either way the frame is 44 cycles and the data bits are 1,1,0,0,0,1,0,1.
- `tx_valid_i` held high with 0x0F then 0xF0 (`CLK_DIV`=4, `bit_used`=8) → exactly one idle-high cycle between the frames. Second start bit at cycle 41, with two `tx_done_o` pulses.
- Assert `rst_i` during data bit 3 of 0x00 → `tx_o`=1 immediately and `tx_ready_o`=1; no `tx_done_o` pulse. After release, 0x81 transmits correctly.
- `bit_used`=5 with macro on, or `bit_used`=9 with macro off → 10-bit frame with no parity bit; frame is 10×`CLK_DIV` cycles.
- Change `tx_data_i` and `bit_used_i` mid-frame while `tx_valid_i`=1 → the frame in progress is unaltered, and no second accept happens until IDLE.
